zeroriscy_ppu_simd_ctrl: RTL
============================

# zeroriscy_ppu_simd_ctrl

Parametrised issue/collect controller that sits in the execute stage between the ID-stage PPU operand/operator signals and `LANES` posit processing units. It splits the 32-bit operands into equal lane slices and issues one operation to all enabled lanes. It collects variable-latency lane results into a registered packed result, then raises a one-cycle ready to the EX-stage ready mux. Beyond the plain single/multi-PPU hookup, it adds a per-lane enable mask, out-of-order lane completion tracking, a completion timeout with error flag, and a flush path.

## Interface
- `XLEN`, 32: packed operand/result width.
- `LANES`, 2: number of PPU lanes. Legal values are 1, 2 and 4. Lane width `W = XLEN/LANES`.
- `OP_W`, `PPU_OP_WIDTH`: operator width, broadcast to every lane.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before forced completion. Must be at least 2.

- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  PPU instruction present in EX. Held high until `ready_o`.
- `flush_i`  in  1  kill the in-flight operation (exception/debug).
- `operand_a_i`, `operand_b_i`, `operand_c_i`  in  XLEN  packed operands.
- `operator_i`  in  OP_W  PPU operation.
- `lane_mask_i`  in  LANES  lane enables. Bit i set means lane i participates.
- `result_o`  out  XLEN  packed result, registered.
- `ready_o`  out  1  operation complete. One-cycle pulse, feeds `ex_ready_o`.
- `err_o`  out  1  completion forced by timeout. Valid with `ready_o`.
- `lane_valid_o`  out  LANES  per-lane issue strobe.
- `lane_op_a_o`, `lane_op_b_o`, `lane_op_c_o`  out  XLEN  registered operand slices. Lane i uses `[W*i +: W]`.
- `lane_operator_o`  out  OP_W  registered operator.
- `lane_flush_o`  out  1  one-cycle kill to all lanes.
- `lane_valid_i`  in  LANES  per-lane result strobe.
- `lane_result_i`  in  XLEN  lane i result on `[W*i +: W]`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `en_i` with `!flush_i`: capture operands, operator and `lane_mask_i` into registers; clear the done vector, result register and timeout counter; go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `lane_valid_o = mask_q`. Go to WAIT.
  - If `mask_q == 0`, go directly to DONE with `result_o = 0`.
- **WAIT**
  - For each lane i with `lane_valid_i[i] & mask_q[i] & !done_q[i]`: write slice i of the result register and set `done_q[i]`.
  - Strobes from masked-off lanes and repeat strobes from already-done lanes are ignored. The first result wins.
  - Lanes may complete in any order and in any combination within a cycle.
  - Go to DONE when `(done_q | captured_this_cycle) == mask_q`.
  - The timeout counter increments each WAIT cycle. When it reaches `TIMEOUT-1` without completion, go to DONE with `err_o = 1`. Slices of missing lanes stay 0.
- **DONE**
  - `ready_o = 1` and `err_o` is valid for this one cycle. Go to IDLE.
  - `result_o` holds its value until the next capture in IDLE.
- Masked-off lane slices of `result_o` are always 0.
- **Flush**
  - `flush_i` in ISSUE or WAIT: next state IDLE, `lane_flush_o` pulses one cycle, no `ready_o`.
  - `flush_i` in IDLE suppresses the issue.
  - `flush_i` in DONE has no effect (the operation retires).
- `lane_valid_i` outside WAIT is ignored.
- Lanes must drop in-flight work on `lane_flush_o`. The controller does not tag responses.
- **Reset values** (all state, asynchronously): state IDLE; `result_o`, `ready_o`, `err_o`, `lane_valid_o`, `lane_flush_o`, lane operand/operator registers, `mask_q`, `done_q` and the counter all 0.

## Timing
- `en_i` sampled in IDLE at cycle 0 → ISSUE at cycle 1 (`lane_valid_o` high) → WAIT from cycle 2.
- A lane responding L cycles after issue (L ≥ 1) strobes at cycle 1+L.
- With slowest lane latency L, `ready_o` is high at cycle 2+L. The earliest `ready_o` is cycle 3.
- `mask_q == 0` gives `ready_o` at cycle 2.
- A timeout gives `ready_o` at cycle 2+TIMEOUT.
- Back-to-back operations: DONE → IDLE. The next instruction's `en_i` is sampled in IDLE, giving at least one idle cycle between operations.
- Lane operand outputs are stable from ISSUE until the next IDLE capture.
- `lane_valid_o` and `lane_flush_o` are registered outputs, never combinational from inputs.

## Test plan
- **Basic completion.** LANES=2, mask=2'b11, a=0x40004000. Lane0 responds at L=1 with 0x1111, lane1 at L=3 with 0x2222 → `ready_o` at cycle 5, `result_o` = 0x22221111, `err_o` = 0.
- **Out-of-order and masking.** LANES=4, mask=4'b0101. Lane2 responds first with 0x33, then lane0 with 0x11. Lane1 strobes 0xFF (masked) → `result_o` = 0x00330011, and lane1's strobe is ignored.
- **Repeat strobes.** Lane0 strobes 0xAAAA, then 0xBBBB before lane1 finishes → slice 0 = 0xAAAA.
- **Timeout.** TIMEOUT=4, mask=2'b11, only lane0 responds with 0x1234 → `ready_o` at cycle 6, `err_o` = 1, `result_o` = 0x00001234.
- **Flush and reset.** `flush_i` at cycle 3 in WAIT → `lane_flush_o` pulses at cycle 4, no `ready_o`, and a late lane strobe in IDLE is ignored. Then issue with mask=0 → `ready_o` at cycle 2, `result_o` = 0. Finally, assert `rst_n` low mid-WAIT → all outputs 0 immediately and state is IDLE.

Source files
------------

// File: rtl/zeroriscy_ppu_simd_ctrl.sv
// zeroriscy_ppu_simd_ctrl
// Issue/collect controller between the ID-stage PPU operand/operator signals
// and LANES posit processing units. Operands are split into equal lane slices,
// one operation is broadcast to every enabled lane, and lane results (which may
// arrive in any order and with any latency) are gathered into a registered
// packed result. Completion is signalled with a one-cycle ready pulse. A stuck
// lane is cut off by a completion timeout that raises err_o, and an in-flight
// operation can be killed with flush_i.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en_i              PPU instruction present in EX (held until ready_o)
//   flush_i           kill the in-flight operation
//   operand_a/b/c_i   packed operands, XLEN bits
//   operator_i        PPU operation, OP_W bits
//   lane_mask_i       per-lane participation mask
//   result_o          registered packed result
//   ready_o           one-cycle completion pulse
//   err_o             completion was forced by timeout (valid with ready_o)
//   lane_valid_o      per-lane issue strobe (registered)
//   lane_op_a/b/c_o   registered operand slices, lane i on [W*i +: W]
//   lane_operator_o   registered operator, broadcast to all lanes
//   lane_flush_o      one-cycle kill to all lanes (registered)
//   lane_valid_i      per-lane result strobe
//   lane_result_i     lane results, lane i on [W*i +: W]
module zeroriscy_ppu_simd_ctrl #(
  parameter int XLEN    = 32,
  parameter int LANES   = 2,
  // Matches PPU_OP_WIDTH of the core's PPU operator encoding.
  parameter int OP_W    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   operand_a_i,
  input  logic [XLEN-1:0]   operand_b_i,
  input  logic [XLEN-1:0]   operand_c_i,
  input  logic [OP_W-1:0]   operator_i,
  input  logic [LANES-1:0]  lane_mask_i,
  output logic [XLEN-1:0]   result_o,
  output logic              ready_o,
  output logic              err_o,
  output logic [LANES-1:0]  lane_valid_o,
  output logic [XLEN-1:0]   lane_op_a_o,
  output logic [XLEN-1:0]   lane_op_b_o,
  output logic [XLEN-1:0]   lane_op_c_o,
  output logic [OP_W-1:0]   lane_operator_o,
  output logic              lane_flush_o,
  input  logic [LANES-1:0]  lane_valid_i,
  input  logic [XLEN-1:0]   lane_result_i
);

  localparam int W     = XLEN / LANES;
  localparam int CNT_W = $clog2(TIMEOUT);
  // Counter value seen during the last WAIT cycle before a forced completion.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_r, state_s;
  logic [LANES-1:0]  mask_r, mask_s;
  logic [LANES-1:0]  done_r, done_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [XLEN-1:0]   result_r, result_s;
  logic [XLEN-1:0]   op_a_r, op_a_s;
  logic [XLEN-1:0]   op_b_r, op_b_s;
  logic [XLEN-1:0]   op_c_r, op_c_s;
  logic [OP_W-1:0]   operator_r, operator_s;
  logic [LANES-1:0]  lane_valid_r, lane_valid_s;
  logic              lane_flush_r, lane_flush_s;
  logic              ready_r, ready_s;
  logic              err_r, err_s;
  logic [LANES-1:0]  cap_s;
  logic              all_done_s;

  // Lanes whose result is accepted this cycle: enabled, not yet done, only while waiting.
  // A flush in the same cycle wins, so nothing is captured for a killed operation.
  always_comb begin
    cap_s = {LANES{1'b0}};
    if ((state_r == ST_WAIT) && !flush_i) begin
      cap_s = lane_valid_i & mask_r & ~done_r;
    end else begin
      cap_s = {LANES{1'b0}};
    end
  end

  // Every enabled lane has delivered, counting this cycle's captures.
  assign all_done_s = ((done_r | cap_s) == mask_r);

  // Next-state, capture and registered-output decode for the issue/collect sequence.
  always_comb begin
    state_s      = state_r;
    mask_s       = mask_r;
    done_s       = done_r;
    cnt_s        = cnt_r;
    result_s     = result_r;
    op_a_s       = op_a_r;
    op_b_s       = op_b_r;
    op_c_s       = op_c_r;
    operator_s   = operator_r;
    lane_valid_s = {LANES{1'b0}};
    lane_flush_s = 1'b0;
    ready_s      = 1'b0;
    err_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (en_i && !flush_i) begin
          state_s      = ST_ISSUE;
          mask_s       = lane_mask_i;
          done_s       = {LANES{1'b0}};
          cnt_s        = {CNT_W{1'b0}};
          result_s     = {XLEN{1'b0}};
          op_a_s       = operand_a_i;
          op_b_s       = operand_b_i;
          op_c_s       = operand_c_i;
          operator_s   = operator_i;
          // Issue strobe is registered so it is high exactly during ISSUE.
          lane_valid_s = lane_mask_i;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (flush_i) begin
          state_s      = ST_IDLE;
          lane_flush_s = 1'b1;
        end else if (mask_r == {LANES{1'b0}}) begin
          // Nothing was issued; retire immediately with an all-zero result.
          state_s = ST_DONE;
          ready_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (flush_i) begin
          state_s      = ST_IDLE;
          lane_flush_s = 1'b1;
        end else begin
          done_s = done_r | cap_s;
          // First strobe per lane wins; later strobes are already masked by done_r.
          for (int i = 0; i < LANES; i++) begin
            if (cap_s[i]) begin
              result_s[i*W +: W] = lane_result_i[i*W +: W];
            end else begin
              result_s[i*W +: W] = result_r[i*W +: W];
            end
          end
          cnt_s = cnt_r + 1'b1;
          if (all_done_s) begin
            state_s = ST_DONE;
            ready_s = 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            // Missing lanes keep their zero slice.
            state_s = ST_DONE;
            ready_s = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end

      ST_DONE: begin
        // A flush here is ignored: the operation has already retired.
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      mask_r       <= {LANES{1'b0}};
      done_r       <= {LANES{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      result_r     <= {XLEN{1'b0}};
      op_a_r       <= {XLEN{1'b0}};
      op_b_r       <= {XLEN{1'b0}};
      op_c_r       <= {XLEN{1'b0}};
      operator_r   <= {OP_W{1'b0}};
      lane_valid_r <= {LANES{1'b0}};
      lane_flush_r <= 1'b0;
      ready_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      mask_r       <= mask_s;
      done_r       <= done_s;
      cnt_r        <= cnt_s;
      result_r     <= result_s;
      op_a_r       <= op_a_s;
      op_b_r       <= op_b_s;
      op_c_r       <= op_c_s;
      operator_r   <= operator_s;
      lane_valid_r <= lane_valid_s;
      lane_flush_r <= lane_flush_s;
      ready_r      <= ready_s;
      err_r        <= err_s;
    end
  end

  assign result_o        = result_r;
  assign ready_o         = ready_r;
  assign err_o           = err_r;
  assign lane_valid_o    = lane_valid_r;
  assign lane_op_a_o     = op_a_r;
  assign lane_op_b_o     = op_b_r;
  assign lane_op_c_o     = op_c_r;
  assign lane_operator_o = operator_r;
  assign lane_flush_o    = lane_flush_r;

endmodule
